// File: rtl/rmii_rx_deframer_pkg.sv
// rmii_rx_deframer_pkg: shared Ethernet constants, FSM state type and the CRC-32 step.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rmii_rx_deframer_pkg;

  // Ethernet field lengths in bytes.
  localparam int ETH_MAC_LEN      = 6;
  localparam int ETH_CRC_LEN      = 4;
  localparam int ETH_PREAMBLE_LEN = 7;

  // Reflected CRC-32 polynomial, and the register value left behind after
  // running the CRC over a frame body that ends in a correct FCS.
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    BODY,
    DROP,
    END
  } rx_state_t;

  // Advance the reflected CRC register by one dibit. d[0] is the earlier bit on
  // the wire, so it is consumed first.
  function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      c = (c >> 1) ^ (((c[0] ^ d[i]) == 1'b1) ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/rmii_rx_deframer_crc32.sv
// rmii_rx_deframer_crc32: reflected CRC-32 accumulator, 2 bits per enabled clock, LSB first.
// Latency: out reflects a dibit on the cycle after inclk samples it.
// Backpressure: none; inclk is a plain enable.
// Ports: clk; rst (async, active high, loads all ones); inclk (consume in);
// shift (drain register two bits at a time instead of accumulating);
// in (data dibit); out (complemented register, i.e. the FCS value).
module rmii_rx_deframer_crc32
  import rmii_rx_deframer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inclk,
  input  logic        shift,
  input  logic [1:0]  in,
  output logic [31:0] out
);

  logic [31:0] crc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '1;
    end else if (inclk) begin
      crc <= shift ? {2'b11, crc[31:2]} : crc32_dibit(crc, in);
    end
  end

  assign out = ~crc;

endmodule

// File: rtl/rmii_rx_deframer.sv
// rmii_rx_deframer: strips RMII preamble/SFD, streams the frame body and flags length/FCS status.
// Latency: rxd -> out 1 cycle; done/err/fcs_ok appear 2 cycles after crs_dv falls.
// Backpressure: none; the RMII line cannot be stalled, so outclk is a pure valid.
// Ports: clk; rst (async, active high); crs_dv/rxd (RMII receive);
// outclk/out (body dibit stream, MAC dst through FCS);
// done/fcs_ok/err (end-of-frame status; err also pulses alone on a bad preamble).
module rmii_rx_deframer
  import rmii_rx_deframer_pkg::*;
#(
  parameter int MIN_PREAMBLE_DIBITS = 8,
  parameter int MIN_BODY_DIBITS     = 256,
  parameter int MAX_BODY_DIBITS     = 6072
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crs_dv,
  input  logic [1:0] rxd,
  output logic       outclk,
  output logic [1:0] out,
  output logic       done,
  output logic       fcs_ok,
  output logic       err
);

  localparam logic [5:0]  MIN_PRE  = 6'(MIN_PREAMBLE_DIBITS);
  localparam logic [12:0] MIN_BODY = 13'(MIN_BODY_DIBITS);
  localparam logic [12:0] MAX_BODY = 13'(MAX_BODY_DIBITS);

  rx_state_t   state;
  logic        crs_q;
  logic [1:0]  rxd_q;
  logic [5:0]  pcnt;
  logic [12:0] bcnt;
  logic        done_q;
  logic        err_q;
  logic        fcs_ok_q;
  logic [31:0] crc_out;
  logic        sfd;
  logic        body_at_max;
  logic        len_bad;
  logic        crc_rst;
  logic        crc_inclk;

  // All decode terms come straight from flops, so sfd is clean enough to use
  // as the CRC's reload: the register holds all ones on the first body dibit.
  assign sfd         = (state == PREAMBLE) && crs_q && (rxd_q == 2'b11) && (pcnt >= MIN_PRE);
  assign body_at_max = (bcnt == MAX_BODY);
  assign len_bad     = (bcnt < MIN_BODY) || (bcnt[1:0] != 2'b00);
  assign crc_rst     = rst | sfd;
  assign crc_inclk   = (state == BODY) && crs_q;

  // outclk is decoded from the same cycle's registered inputs so that it lines
  // up with out, which is the registered dibit itself.
  assign outclk = (state == BODY) && crs_q && !body_at_max;
  assign out    = rxd_q;
  assign done   = done_q;
  assign err    = err_q;
  assign fcs_ok = fcs_ok_q;

  rmii_rx_deframer_crc32 u_crc32 (
    .clk   (clk),
    .rst   (crc_rst),
    .inclk (crc_inclk),
    .shift (1'b0),
    .in    (rxd_q),
    .out   (crc_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crs_q    <= 1'b0;
      rxd_q    <= 2'b00;
      state    <= IDLE;
      pcnt     <= '0;
      bcnt     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      fcs_ok_q <= 1'b0;
    end else begin
      crs_q    <= crs_dv;
      rxd_q    <= rxd;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      fcs_ok_q <= 1'b0;
      case (state)
        IDLE: begin
          if (crs_q) begin
            if (rxd_q == 2'b01) begin
              state <= PREAMBLE;
              pcnt  <= 6'd1;
            end else begin
              state <= DROP;
            end
          end
        end
        PREAMBLE: begin
          if (!crs_q) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else if (rxd_q == 2'b01) begin
            if (pcnt != 6'd63) pcnt <= pcnt + 6'd1;
          end else if (sfd) begin
            state <= BODY;
            bcnt  <= '0;
          end else begin
            // Stray dibit or an SFD that came too early.
            err_q <= 1'b1;
            state <= DROP;
          end
        end
        BODY: begin
          if (!crs_q) begin
            // Status is latched here so it is presented during the END cycle.
            state    <= END;
            done_q   <= 1'b1;
            err_q    <= len_bad;
            fcs_ok_q <= !len_bad && (~crc_out == CRC_RESIDUE);
          end else if (body_at_max) begin
            state  <= DROP;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            bcnt <= bcnt + 13'd1;
          end
        end
        DROP: begin
          if (!crs_q) state <= IDLE;
        end
        END: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rmii_rx_deframer.sv
`timescale 1ns/1ps
module tb_rmii_rx_deframer;
  import rmii_rx_deframer_pkg::*;

  localparam int MIN_PRE   = 8;
  localparam int MIN_BODY  = 256;
  localparam int MAX_BODY  = 6072;
  localparam int STD_PRE   = ETH_PREAMBLE_LEN * 4 + 3;  // 0x55 x7 then 01,01,01 of 0xD5
  localparam int LOOP_DATA = 2 * ETH_MAC_LEN + 58;       // 74-byte body with the FCS

  typedef struct {
    int n_out;
    int n_done;
    int n_err;
    int n_fcs;
    int n_bad;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       crs_dv = 1'b0;
  logic [1:0] rxd = 2'b00;
  logic       outclk, done, fcs_ok, err;
  logic [1:0] out;

  int checks = 0;
  int errors = 0;

  logic [31:0] crc_tbl [256];
  logic [7:0]  tx_bytes [$];
  logic [1:0]  tx_body [$];
  logic [1:0]  rx_q [$];
  int n_done = 0, n_err = 0, n_fcs = 0, n_stray = 0;

  always #5 clk = ~clk;

  rmii_rx_deframer #(
    .MIN_PREAMBLE_DIBITS (MIN_PRE),
    .MIN_BODY_DIBITS     (MIN_BODY),
    .MAX_BODY_DIBITS     (MAX_BODY)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .crs_dv (crs_dv),
    .rxd    (rxd),
    .outclk (outclk),
    .out    (out),
    .done   (done),
    .fcs_ok (fcs_ok),
    .err    (err)
  );

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (outclk) rx_q.push_back(out);
    if (done) n_done++;
    if (err) n_err++;
    if (fcs_ok) begin
      if (done) n_fcs++;
      else n_stray++;
    end
  end

  // Byte-wise table CRC over the first n bytes of b; returns the FCS value.
  function automatic logic [31:0] fcs_of(input logic [7:0] b[$], input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) c = crc_tbl[c[7:0] ^ b[i]] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic build_frame(input int ndata);
    logic [31:0] f;
    tx_bytes.delete();
    tx_body.delete();
    for (int i = 0; i < ndata; i++) tx_bytes.push_back(8'($urandom));
    f = fcs_of(tx_bytes, ndata);
    for (int k = 0; k < 4; k++) tx_bytes.push_back(f[8*k +: 8]);
    foreach (tx_bytes[i]) for (int k = 0; k < 4; k++) tx_body.push_back(tx_bytes[i][2*k +: 2]);
  endtask

  // Expected outcome of sending tx_body after npre preamble dibits and an SFD.
  function automatic obs_t predict(input int npre);
    obs_t e;
    int len;
    bit bad;
    logic [7:0] b[$];
    logic [31:0] got;
    e = '{0, 0, 0, 0, 0};
    len = tx_body.size();
    if (npre < MIN_PRE) begin
      e.n_err = 1;
      return e;
    end
    e.n_out  = (len > MAX_BODY) ? MAX_BODY : len;
    e.n_done = 1;
    bad = (len > MAX_BODY) || (len < MIN_BODY) || (len % 4 != 0);
    e.n_err = bad ? 1 : 0;
    if (!bad) begin
      for (int i = 0; i < len / 4; i++)
        b.push_back({tx_body[4*i+3], tx_body[4*i+2], tx_body[4*i+1], tx_body[4*i]});
      got = {b[len/4-1], b[len/4-2], b[len/4-3], b[len/4-4]};
      e.n_fcs = (got == fcs_of(b, len / 4 - 4)) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic drive(input logic c, input logic [1:0] d);
    @(negedge clk);
    crs_dv = c;
    rxd    = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00);
    #1;
  endtask

  task automatic send(input int npre);
    for (int i = 0; i < npre; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    foreach (tx_body[i]) drive(1'b1, tx_body[i]);
  endtask

  task automatic run_frame(input int npre, input int gap, output obs_t o);
    int q0, d0, e0, f0;
    q0 = rx_q.size(); d0 = n_done; e0 = n_err; f0 = n_fcs;
    send(npre);
    idle(gap);
    o.n_out  = rx_q.size() - q0;
    o.n_done = n_done - d0;
    o.n_err  = n_err - e0;
    o.n_fcs  = n_fcs - f0;
    o.n_bad  = 0;
    for (int i = 0; i < o.n_out && i < tx_body.size(); i++)
      if (rx_q[q0 + i] !== tx_body[i]) o.n_bad++;
  endtask

  task automatic test_reset();
    rst = 1'b1; crs_dv = 1'b1; rxd = 2'b11;
    #1;
    checks++; if ({outclk, out, done, fcs_ok, err} !== 6'b0) begin errors++; $display("FAIL reset_async outputs: got %b want 000000", {outclk, out, done, fcs_ok, err}); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({outclk, out, done, fcs_ok, err} !== 6'b0) begin errors++; $display("FAIL reset_clocked outputs: got %b want 000000", {outclk, out, done, fcs_ok, err}); end
    @(negedge clk);
    rst = 1'b0; crs_dv = 1'b0; rxd = 2'b00;
    idle(4);
    checks++; if (n_done + n_err + rx_q.size() !== 0) begin errors++; $display("FAIL reset_release activity: got %0d want 0", n_done + n_err + rx_q.size()); end
  endtask

  task automatic test_loopback();
    obs_t o;
    for (int r = 0; r < 3; r++) begin
      build_frame(LOOP_DATA);
      run_frame(STD_PRE, 4, o);
      checks++; if (o.n_out !== 296) begin errors++; $display("FAIL loopback outclk count: got %0d want 296", o.n_out); end
      checks++; if (o.n_bad !== 0) begin errors++; $display("FAIL loopback data: got %0d wrong dibits want 0", o.n_bad); end
      checks++; if ({o.n_done, o.n_fcs, o.n_err} !== {32'd1, 32'd1, 32'd0}) begin errors++; $display("FAIL loopback status: got done %0d fcs_ok %0d err %0d want 1 1 0", o.n_done, o.n_fcs, o.n_err); end
    end
  endtask

  task automatic test_bad_fcs();
    obs_t o;
    int k;
    build_frame(LOOP_DATA);
    k = LOOP_DATA * 4 + $urandom_range(0, 15);
    tx_body[k] = ~tx_body[k];
    run_frame(STD_PRE, 4, o);
    checks++; if (o.n_out !== 296) begin errors++; $display("FAIL bad_fcs outclk count: got %0d want 296", o.n_out); end
    checks++; if ({o.n_done, o.n_fcs, o.n_err} !== {32'd1, 32'd0, 32'd0}) begin errors++; $display("FAIL bad_fcs status: got done %0d fcs_ok %0d err %0d want 1 0 0", o.n_done, o.n_fcs, o.n_err); end
  endtask

  task automatic test_short_preamble();
    obs_t o;
    for (int npre = 6; npre <= 7; npre++) begin
      build_frame(LOOP_DATA);
      run_frame(npre, 4, o);
      checks++; if ({o.n_out, o.n_done, o.n_err} !== {32'd0, 32'd0, 32'd1}) begin errors++; $display("FAIL short_pre_%0d: got outclk %0d done %0d err %0d want 0 0 1", npre, o.n_out, o.n_done, o.n_err); end
    end
    build_frame(LOOP_DATA);
    run_frame(MIN_PRE, 4, o);
    checks++; if ({o.n_out, o.n_fcs, o.n_err} !== {32'd296, 32'd1, 32'd0}) begin errors++; $display("FAIL min_pre accept: got outclk %0d fcs_ok %0d err %0d want 296 1 0", o.n_out, o.n_fcs, o.n_err); end
  endtask

  task automatic test_runt();
    obs_t o;
    build_frame(36);
    run_frame(STD_PRE, 4, o);
    checks++; if ({o.n_out, o.n_done, o.n_err, o.n_fcs} !== {32'd160, 32'd1, 32'd1, 32'd0}) begin errors++; $display("FAIL runt_40B: got outclk %0d done %0d err %0d fcs_ok %0d want 160 1 1 0", o.n_out, o.n_done, o.n_err, o.n_fcs); end
    build_frame(60);
    tx_body.push_back(2'($urandom));
    run_frame(STD_PRE, 4, o);
    checks++; if ({o.n_out, o.n_done, o.n_err, o.n_fcs} !== {32'd257, 32'd1, 32'd1, 32'd0}) begin errors++; $display("FAIL misalign_257: got outclk %0d done %0d err %0d fcs_ok %0d want 257 1 1 0", o.n_out, o.n_done, o.n_err, o.n_fcs); end
    build_frame(60);
    run_frame(STD_PRE, 4, o);
    checks++; if ({o.n_out, o.n_done, o.n_err, o.n_fcs} !== {32'd256, 32'd1, 32'd0, 32'd1}) begin errors++; $display("FAIL min_body_256: got outclk %0d done %0d err %0d fcs_ok %0d want 256 1 0 1", o.n_out, o.n_done, o.n_err, o.n_fcs); end
  endtask

  task automatic test_oversize();
    obs_t o;
    tx_body.delete();
    for (int i = 0; i < 6100; i++) tx_body.push_back(2'($urandom));
    run_frame(STD_PRE, 4, o);
    checks++; if (o.n_out !== MAX_BODY) begin errors++; $display("FAIL oversize outclk count: got %0d want %0d", o.n_out, MAX_BODY); end
    checks++; if (o.n_bad !== 0) begin errors++; $display("FAIL oversize data: got %0d wrong dibits want 0", o.n_bad); end
    checks++; if ({o.n_done, o.n_err, o.n_fcs} !== {32'd1, 32'd1, 32'd0}) begin errors++; $display("FAIL oversize status: got done %0d err %0d fcs_ok %0d want 1 1 0", o.n_done, o.n_err, o.n_fcs); end
    build_frame(1514);
    run_frame(STD_PRE, 4, o);
    checks++; if ({o.n_out, o.n_done, o.n_err, o.n_fcs} !== {32'd6072, 32'd1, 32'd0, 32'd1}) begin errors++; $display("FAIL max_body_1518B: got outclk %0d done %0d err %0d fcs_ok %0d want 6072 1 0 1", o.n_out, o.n_done, o.n_err, o.n_fcs); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int q0, d0, e0, nbad;
    build_frame(LOOP_DATA);
    q0 = rx_q.size(); d0 = n_done; e0 = n_err;
    for (int i = 0; i < STD_PRE; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < 100; i++) drive(1'b1, tx_body[i]);
    @(negedge clk);
    #2;
    rst = 1'b1; crs_dv = 1'b0; rxd = 2'b00;
    #1;
    checks++; if ({outclk, out, done, fcs_ok, err} !== 6'b0) begin errors++; $display("FAIL reset_mid outputs: got %b want 000000", {outclk, out, done, fcs_ok, err}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(6);
    nbad = 0;
    for (int i = 0; i < 100; i++) if (rx_q[q0 + i] !== tx_body[i]) nbad++;
    checks++; if ({rx_q.size() - q0, nbad} !== {32'd100, 32'd0}) begin errors++; $display("FAIL reset_mid body: got %0d dibits %0d wrong want 100 0", rx_q.size() - q0, nbad); end
    checks++; if ({n_done - d0, n_err - e0} !== {32'd0, 32'd0}) begin errors++; $display("FAIL reset_mid status: got done %0d err %0d want 0 0", n_done - d0, n_err - e0); end
    build_frame(LOOP_DATA);
    run_frame(STD_PRE, 4, o);
    checks++; if ({o.n_out, o.n_fcs, o.n_err} !== {32'd296, 32'd1, 32'd0}) begin errors++; $display("FAIL after_reset frame: got outclk %0d fcs_ok %0d err %0d want 296 1 0", o.n_out, o.n_fcs, o.n_err); end
  endtask

  task automatic test_back_to_back();
    int q0, d0, e0, f0;
    q0 = rx_q.size(); d0 = n_done; e0 = n_err; f0 = n_fcs;
    build_frame(LOOP_DATA);
    send(STD_PRE);
    idle(1);
    build_frame(60);
    send(STD_PRE);
    idle(6);
    checks++; if (rx_q.size() - q0 !== 296 + 256) begin errors++; $display("FAIL b2b outclk count: got %0d want %0d", rx_q.size() - q0, 296 + 256); end
    checks++; if ({n_done - d0, n_fcs - f0, n_err - e0} !== {32'd2, 32'd2, 32'd0}) begin errors++; $display("FAIL b2b status: got done %0d fcs_ok %0d err %0d want 2 2 0", n_done - d0, n_fcs - f0, n_err - e0); end
  endtask

  task automatic test_random();
    obs_t o, e;
    int npre, k;
    for (int r = 0; r < 8; r++) begin
      npre = $urandom_range(6, 20);
      build_frame($urandom_range(50, 90));
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, tx_body.size() - 1);
        tx_body[k] = tx_body[k] ^ 2'($urandom_range(1, 3));
      end
      if ($urandom_range(0, 3) == 0) tx_body.push_back(2'($urandom));
      e = predict(npre);
      run_frame(npre, 4, o);
      checks++; if (o !== e) begin errors++; $display("FAIL random_%0d: got out %0d done %0d err %0d fcs %0d bad %0d want %0d %0d %0d %0d %0d", r, o.n_out, o.n_done, o.n_err, o.n_fcs, o.n_bad, e.n_out, e.n_done, e.n_err, e.n_fcs, e.n_bad); end
    end
    checks++; if (n_stray !== 0) begin errors++; $display("FAIL fcs_ok_without_done: got %0d want 0", n_stray); end
  endtask

  initial begin
    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tbl[n] = c;
    end
    test_reset();
    test_loopback();
    test_bad_fcs();
    test_short_preamble();
    test_runt();
    test_oversize();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
